dmac_ahb_sram_slave: RTL and testbench
======================================

# dmac_ahb_sram_slave

AHB-Lite responder that models a word-organised on-chip SRAM with programmable wait states, byte-lane write strobes and two-cycle ERROR responses. It sits on the system bus opposite the DMA channel master. It is the source and destination peripheral for channel transfers in integration and regression benches, and a synthesizable scratch memory in the SoC.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- WAIT_STATES, 0: number of HREADYOUT-low cycles inserted in every OKAY data phase, 0..15.
- BASE_ADDR, 32'h0000_0000: byte base address; aligned to 4*DEPTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 write, 0 read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; other values are illegal.
- HBURST  in  3  burst type; informational only, each beat is handled independently.
- HWSTRB  in  4  write byte strobes, data-phase aligned with HWDATA.
- HWDATA  in  32  write data.
- HREADY  in  1  bus-wide ready; the address phase is sampled only when this is 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.
- xfer_count  out  32  count of completed OKAY transfers.

## Operation
- Address-phase acceptance: a transfer is accepted when HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance the slave registers HADDR, HWRITE and HSIZE, plus the size-derived lane mask and an error flag.
- IDLE/BUSY with HSEL=1 and HREADY=1: zero-wait OKAY, no memory access.
- Address offset: off = HADDR - BASE_ADDR, 32-bit unsigned. Word index is off[log2(DEPTH)+1:2].
- Error conditions, any of the following:
  - off >= 4*DEPTH;
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 0.
- Lane mask:
  - byte: one-hot on HADDR[1:0] (00->0001, 01->0010, 10->0100, 11->1000);
  - halfword: HADDR[1]=0 -> 0011, HADDR[1]=1 -> 1100;
  - word: 1111.
- Write: each lane i with mask[i] & HWSTRB[i] is updated from HWDATA[8i+7:8i]. Other lanes are unchanged. An all-zero effective strobe is an OKAY no-op.
- Read: HRDATA = mem[index] (full word, all lanes) in the final data-phase cycle. It is 0 in every other cycle.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted error transfer -> ERR1. Accepted OKAY transfer with WAIT_STATES>0 -> WAIT. Accepted OKAY transfer with WAIT_STATES=0 -> DATA.
  - WAIT: HREADYOUT=0. A wait counter loads WAIT_STATES-1 and decrements. At 0 -> DATA.
  - DATA: HREADYOUT=1. The write commits and xfer_count increments at the edge ending this cycle. A pipelined next transfer may be accepted in the same cycle; it follows the same branches as from IDLE. Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase can be accepted here and branches as from IDLE.
- xfer_count increments once per completed OKAY NONSEQ/SEQ beat and wraps from 32'hFFFF_FFFF to 0. It never increments for errors or for IDLE/BUSY.
- Memory contents are not reset.

## Timing
- Reset values:
  - HREADYOUT=1;
  - HRESP=0;
  - HRDATA=0;
  - xfer_count=0;
  - FSM=IDLE.
- Reset is asynchronous and effective immediately. Assertion mid-data-phase aborts the pending write; no lanes change.
- Accepted in cycle N: the data phase spans cycles N+1..N+1+WAIT_STATES, and HREADYOUT is high only in N+1+WAIT_STATES.
- Back-to-back: with WAIT_STATES=0, one beat completes per cycle. A read of the address written in the immediately preceding beat returns the new data, because the write commits before the read data phase.
- ERROR response: HRESP is high for exactly 2 cycles, with HREADYOUT low then high. No memory or counter update occurs.
- HSEL=0 or HREADY=0 in the address phase: no acceptance, and the current state proceeds unchanged.

## Test plan
- **Reset:** rst pulse mid-WAIT (WAIT_STATES=2), then release -> HREADYOUT=1, HRESP=0, HRDATA=0, xfer_count=0. The target word keeps its old value.
- **Word write/read with waits (WAIT_STATES=3, BASE_ADDR=0):** write 32'hDEADBEEF to 0x10, then read 0x10 -> HREADYOUT low for 3 cycles per beat, HRDATA=32'hDEADBEEF, xfer_count=2.
- **Byte/halfword lanes:** word 0x20=0, then byte write 0xAA to 0x23, then halfword write 0x1234 to 0x20, then word read -> 32'hAA00_1234.
- **Pipelined 4-beat INCR burst (WAIT_STATES=0):** writes to 0x40..0x4C, then a burst read -> one beat per cycle, data read back matches, xfer_count +8.
- **Errors:** word at 0x02, HSIZE=3, and address 4*DEPTH -> each gives HRESP=1 for 2 cycles (HREADYOUT 0 then 1), with memory and xfer_count unchanged. The next legal NONSEQ accepted in ERR2 completes OKAY.
- **Counter wrap:** force xfer_count to 32'hFFFF_FFFF, then one OKAY read -> xfer_count=0.

Source files
------------

// File: rtl/dmac_ahb_sram_slave.sv
// AHB-Lite responder modelling a word-organised SRAM with programmable wait
// states, byte-lane write strobes and two-cycle ERROR responses.
`timescale 1ns/1ps
module dmac_ahb_sram_slave #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HWSTRB,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] xfer_count
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0] idx_reg;
  logic          write_reg;
  logic [3:0]    mask_reg;
  logic [31:0]   xfer_count_reg;

  logic [31:0]   off;
  logic [AW-1:0] a_idx;
  logic          accept;
  logic          addr_err;
  logic [3:0]    a_mask;
  logic [3:0]    we;
  logic          unused_bits;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_raw_reg;
  logic [31:0]   fwd_data_reg;
  logic [3:0]    fwd_en_reg;
  logic [31:0]   rd_word;

  assign off         = HADDR - BASE_ADDR;
  assign a_idx       = off[AW+1:2];
  assign accept      = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign unused_bits = ^{HBURST, HTRANS[0]};

  assign HREADYOUT  = !((state_reg == S_WAIT) || (state_reg == S_ERR1));
  assign HRESP      = (state_reg == S_ERR1) || (state_reg == S_ERR2);
  assign xfer_count = xfer_count_reg;

  always_comb begin
    addr_err = (off >= SPAN);
    a_mask   = 4'b0000;
    case (HSIZE)
      3'd0: a_mask = 4'b0001 << HADDR[1:0];
      3'd1: begin
        a_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) addr_err = 1'b1;
      end
      3'd2: begin
        a_mask = 4'b1111;
        if (HADDR[1:0] != 2'b00) addr_err = 1'b1;
      end
      default: addr_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_WAIT: begin
        if (wait_cnt_reg == 4'd0) state_next = S_DATA;
        else wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      S_ERR1: state_next = S_ERR2;
      // IDLE, DATA and ERR2 all present HREADYOUT=1 and may take a new address phase
      default: begin
        if (accept) begin
          if (addr_err) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      wait_cnt_reg   <= 4'd0;
      idx_reg        <= '0;
      write_reg      <= 1'b0;
      mask_reg       <= 4'b0000;
      xfer_count_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        idx_reg   <= a_idx;
        write_reg <= HWRITE;
        mask_reg  <= a_mask;
      end
      if (state_reg == S_DATA) xfer_count_reg <= xfer_count_reg + 32'd1;
    end
  end

  // A read accepted in the cycle its predecessor's write commits sees the new lanes via forwarding
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign we[gi] = (state_reg == S_DATA) && write_reg && mask_reg[gi] && HWSTRB[gi];
      assign rd_word[8*gi +: 8] = fwd_en_reg[gi] ? fwd_data_reg[8*gi +: 8] : rd_raw_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx_reg][8*i +: 8] <= HWDATA[8*i +: 8];
    end
    if (accept) begin
      rd_raw_reg   <= mem[a_idx];
      fwd_en_reg   <= we & {4{idx_reg == a_idx}};
      fwd_data_reg <= HWDATA;
    end
  end

  assign HRDATA = ((state_reg == S_DATA) && !write_reg) ? rd_word : 32'd0;

endmodule

// File: tb/tb_dmac_ahb_sram_slave.sv
// Randomised scoreboard bench for dmac_ahb_sram_slave: a spec-level memory model
// predicts each beat, a monitor checks every completed data phase.
`timescale 1ns/1ps
module tb_dmac_ahb_sram_slave;
  localparam int          DEPTH = 64;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HWSTRB;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] xfer_count;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  dmac_ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWSTRB(HWSTRB),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .xfer_count(xfer_count)
  );

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_cnt;
  int          checks   = 0;
  int          failures = 0;
  int          txn_n    = 0;
  bit          in_dp    = 1'b0;
  int          wcnt     = 0;
  bit          low_resp = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected response straight from the address/size/strobe rules
  task automatic model_push(bit wr, logic [31:0] addr, logic [2:0] size,
                            logic [31:0] wdata, logic [3:0] strb);
    exp_t        e;
    logic [31:0] o;
    logic [3:0]  lanes;
    int          idx;
    o       = addr - BASE;
    e.err   = (o >= 32'(4 * DEPTH)) || (size > 3'd2) ||
              (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    e.rd    = !wr;
    e.rdata = 32'd0;
    if (size == 3'd0)      lanes = 4'b0001 << addr[1:0];
    else if (size == 3'd1) lanes = addr[1] ? 4'b1100 : 4'b0011;
    else                   lanes = 4'b1111;
    if (!e.err) begin
      idx = int'(o >> 2);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (lanes[i] && strb[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        e.rdata = model_mem[idx];
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!HREADYOUT) begin
      n++;
      if (n > 64) begin
        failures++;
        $display("FAIL ready_timeout hreadyout=%0b required=1", HREADYOUT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bus stalled");
      end
      @(negedge clk);
    end
  endtask

  // Drive an address phase, wait for acceptance, then present its write data
  task automatic issue(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                       logic [3:0] strb, bit seq, bit track);
    HSEL   = 1'b1;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = seq ? 2'b11 : 2'b10;
    HBURST = seq ? 3'b011 : 3'b000;
    wait_ready();
    if (track) model_push(wr, addr, size, wdata, strb);
    @(posedge clk);
    #1;
    HWDATA = wdata;
    HWSTRB = strb;
  endtask

  task automatic go_idle();
    HTRANS = 2'b00;
    HSEL   = 1'($urandom_range(0, 1));
    wait_ready();
    @(posedge clk);
    #1;
    HWSTRB = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp && !HREADYOUT) begin
        wcnt++;
        if (HRESP) low_resp = 1'b1;
        chk("hrdata_wait", HRDATA, 32'd0);
      end else if (in_dp) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          cur = sb_q.pop_front();
          txn_n++;
          $display("txn %0d %s %s hrdata=%h xfer_count=%0d", txn_n, cur.rd ? "RD" : "WR",
                   cur.err ? "ERROR" : "OKAY", HRDATA, xfer_count);
          chk("wait_cycles", 32'(wcnt), cur.err ? 32'd1 : 32'(WS));
          chk("hresp_low", 32'(low_resp), 32'(cur.err));
          chk("hresp", 32'(HRESP), 32'(cur.err));
          chk("hrdata", HRDATA, cur.rdata);
          chk("xfer_count", xfer_count, exp_cnt);
          if (!cur.err) exp_cnt = exp_cnt + 32'd1;
        end
      end else begin
        chk("hrdata_idle", HRDATA, 32'd0);
      end
      if (HREADYOUT) begin
        in_dp    = HSEL && HTRANS[1];
        wcnt     = 0;
        low_resp = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    int          r;
    HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HWSTRB = 4'd0; HWDATA = 32'd0;
    exp_cnt = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_xfer_count", xfer_count, 32'd0);
    @(posedge clk);
    #1;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, BASE + 32'(4 * i), 3'd2, $urandom, 4'hF, i != 0, 1'b1);
    go_idle();

    // Reset in the middle of a wait-stated write: word 0x10 must keep its value
    issue(1'b1, BASE + 32'h10, 3'd2, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("midrst_hresp", 32'(HRESP), 32'd0);
    chk("midrst_hrdata", HRDATA, 32'd0);
    chk("midrst_xfer_count", xfer_count, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_cnt = 32'd0;
    @(posedge clk);
    #1;
    issue(1'b0, BASE + 32'h10, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();

    // Word write/read with waits
    issue(1'b1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h10, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();

    // Byte and halfword lanes
    issue(1'b1, BASE + 32'h20, 3'd2, 32'h0000_0000, 4'hF, 1'b0, 1'b1);
    issue(1'b1, BASE + 32'h23, 3'd0, 32'hAA00_0000, 4'b1000, 1'b0, 1'b1);
    issue(1'b1, BASE + 32'h20, 3'd1, 32'h0000_1234, 4'b0011, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h20, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();

    // Pipelined 4-beat INCR bursts
    for (int i = 0; i < 4; i++)
      issue(1'b1, BASE + 32'h40 + 32'(4 * i), 3'd2, $urandom, 4'hF, i != 0, 1'b1);
    for (int i = 0; i < 4; i++)
      issue(1'b0, BASE + 32'h40 + 32'(4 * i), 3'd2, 32'd0, 4'h0, i != 0, 1'b1);
    go_idle();

    // Read immediately after a write to the same word (full and partial lanes)
    issue(1'b1, BASE + 32'h50, 3'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h50, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    issue(1'b1, BASE + 32'h55, 3'd0, 32'h0000_7700, 4'b0010, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h54, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();

    // ERROR responses, each followed by a legal beat taken in ERR2
    issue(1'b1, BASE + 32'h02, 3'd2, 32'h5555_5555, 4'hF, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h00, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    issue(1'b1, BASE + 32'h30, 3'd3, 32'h6666_6666, 4'hF, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h30, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'(4 * DEPTH), 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    issue(1'b0, BASE + 32'h40, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();

    // BUSY with HSEL=1 is a zero-wait no-op
    HSEL = 1'b1;
    HTRANS = 2'b01;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 15) == 0)
        addr = BASE + 32'(4 * DEPTH) + $urandom_range(0, 255);
      else
        addr = BASE + $urandom_range(0, 4 * DEPTH - 1);
      if (size == 3'd2 && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if (size == 3'd1 && $urandom_range(0, 3) != 0) addr[0] = 1'b0;
      issue(1'($urandom_range(0, 1)), addr, size, $urandom, 4'($urandom), 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    // Counter wrap
    force dut.xfer_count_reg = 32'hFFFF_FFFF;
    #1 release dut.xfer_count_reg;
    exp_cnt = 32'hFFFF_FFFF;
    issue(1'b0, BASE + 32'h10, 3'd2, 32'd0, 4'h0, 1'b0, 1'b1);
    go_idle();
    chk("xfer_count_wrap", xfer_count, 32'd0);

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
